// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin multi-client APB master
// Grants one local client at a time and runs it through APB SETUP/ACCESS.
module apb_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                any_valid;
    logic [IDX_W-1:0]    grant_idx;
    logic                timeout_hit;
    logic                done;
    int                  idx;

    // Search upward from the pointer with wrap; the first hit wins.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    assign timeout_hit = (TIMEOUT > 0) && (state_q == ACCESS) && !pready && (cnt_q == CNT_LAST);
    assign done        = (state_q == ACCESS) && (pready || timeout_hit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel      = (state_q == SETUP) || (state_q == ACCESS);
        penable   = (state_q == ACCESS);
        req_ready = '0;
        if (resetn && (state_q == IDLE) && any_valid) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    always_comb begin
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        cnt_d       = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if ((state_q == IDLE) && any_valid) begin
            paddr_d  = req_addr[grant_idx*ADDR_W +: ADDR_W];
            pwrite_d = req_write[grant_idx];
            pwdata_d = req_wdata[grant_idx*DATA_W +: DATA_W];
            gnt_d    = grant_idx;
        end
        if (done) begin
            rsp_valid_d = NUM_REQ'(1) << gnt_q;
            rsp_err_d   = timeout_hit || pslverr;
            rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
            ptr_d       = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;
        end else if ((TIMEOUT > 0) && (state_q == ACCESS)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            gnt_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
